// File: rtl/alu_stage.sv
// Multi-cycle 8-bit ALU: captures operands on start, registers result/flags, pulses result_valid.
// Optional shift-add multiplier for op 7 is compiled in when ALU_MUL_EN is defined.
module alu_stage (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] bus_a,
    input  logic [7:0] bus_b,
    output logic       busy,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_n,
    output logic       illegal
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] a_q, b_q;
    logic [2:0] op_q;
    logic [8:0] sum, diff;
    logic [7:0] alu_res;
    logic       alu_c, alu_ill;

`ifdef ALU_MUL_EN
    logic [2:0]  cnt;
    logic [15:0] acc;
`endif

    assign busy         = (state != S_IDLE);
    assign result_valid = (state == S_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef ALU_MUL_EN
                    state_nx = (op == OP_MUL) ? S_MUL : S_EXEC;
`else
                    state_nx = S_EXEC;
`endif
                end
            end
            S_EXEC: state_nx = S_DONE;
            S_MUL: begin
`ifdef ALU_MUL_EN
                // Final product is published through EXEC so MUL and non-MUL share one writeback path.
                if (cnt == 3'd7) state_nx = S_EXEC;
`else
                state_nx = S_IDLE;
`endif
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        alu_res = 8'h00;
        alu_c   = 1'b0;
        alu_ill = 1'b0;
        case (op_q)
            OP_ADD: begin alu_res = sum[7:0];  alu_c = sum[8];  end
            OP_SUB: begin alu_res = diff[7:0]; alu_c = diff[8]; end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin alu_res = {a_q[6:0], 1'b0}; alu_c = a_q[7]; end
            OP_SHR: begin alu_res = {1'b0, a_q[7:1]}; alu_c = a_q[0]; end
            OP_MUL: begin
`ifdef ALU_MUL_EN
                alu_res = acc[7:0];
                alu_c   = |acc[15:8];
`else
                alu_ill = 1'b1;
`endif
            end
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            op_q    <= 3'd0;
            result  <= 8'h00;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_n  <= 1'b0;
            illegal <= 1'b0;
`ifdef ALU_MUL_EN
            cnt     <= 3'd0;
            acc     <= 16'h0000;
`endif
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                a_q  <= bus_a;
                b_q  <= bus_b;
                op_q <= op;
`ifdef ALU_MUL_EN
                cnt  <= 3'd0;
                acc  <= 16'h0000;
`endif
            end
            if (state == S_EXEC) begin
                result  <= alu_res;
                flag_z  <= (alu_res == 8'h00);
                flag_c  <= alu_c;
                flag_n  <= alu_res[7];
                illegal <= alu_ill;
            end
`ifdef ALU_MUL_EN
            if (state == S_MUL) begin
                if (b_q[cnt]) acc <= acc + ({8'h00, a_q} << cnt);
                cnt <= cnt + 3'd1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_stage.sv
// Randomized + directed bench for alu_stage against a cycle-level behavioural model.
module tb_alu_stage;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] bus_a = 8'h00, bus_b = 8'h00;
    logic       busy, result_valid, flag_z, flag_c, flag_n, illegal;
    logic [7:0] result;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_stage dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .bus_a(bus_a), .bus_b(bus_b),
        .busy(busy), .result(result), .result_valid(result_valid),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic void ref_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] r, output logic c, output logic ill);
        int unsigned x;
        ill = 1'b0;
        c   = 1'b0;
        case (o)
            3'd0: begin x = a + b;          r = x[7:0]; c = (x > 255); end
            3'd1: begin x = (a + 256 - b);  r = x[7:0]; c = (a < b);   end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin x = a * 2;          r = x[7:0]; c = a[7]; end
            3'd6: begin r = a / 2;          c = a[0]; end
            default: begin
                if (MUL_EN) begin x = a * b; r = x[7:0]; c = (x > 255); end
                else begin r = 8'h00; ill = 1'b1; end
            end
        endcase
    endfunction

    // Model: cycles of busy remaining after acceptance; results publish when one cycle is left.
    int         rem = 0;
    logic [7:0] p_res, m_res = 8'h00;
    logic       p_c, p_ill;
    logic       m_valid = 0, m_z = 0, m_c = 0, m_n = 0, m_ill = 0;

    always @(posedge clk) begin
        if (reset) begin
            rem = 0; m_valid = 0; m_res = 0; m_z = 0; m_c = 0; m_n = 0; m_ill = 0;
        end else begin
            m_valid = 0;
            if (rem > 0) begin
                rem = rem - 1;
                if (rem == 1) begin
                    m_res = p_res; m_c = p_c; m_ill = p_ill;
                    m_z = (p_res == 0); m_n = p_res[7]; m_valid = 1;
                end
            end else if (start) begin
                ref_op(op, bus_a, bus_b, p_res, p_c, p_ill);
                rem = (MUL_EN && op == 3'd7) ? 10 : 2;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en)
            chk("model", {busy, result_valid, result, flag_z, flag_c, flag_n, illegal},
                {(rem > 0), m_valid, m_res, m_z, m_c, m_n, m_ill});
    endtask

    task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic ez, input logic ec, input logic en,
                         input logic ei, input int lat);
        int k;
        k = 0;
        while (busy && k < 30) begin tick(); k++; end
        start = 1; op = o; bus_a = a; bus_b = b;
        tick();
        start = 0; bus_a = 8'($urandom); bus_b = 8'($urandom);
        k = 0;
        while (!result_valid && k < 30) begin tick(); k++; end
        chk("latency", k, lat);
        chk("result", {result, flag_z, flag_c, flag_n, illegal}, {er, ez, ec, en, ei});
    endtask

    initial begin
        int pulses;
        logic [7:0] seen;
        reset = 1;
        tick(); tick();
        chk("reset_state", {busy, result_valid, result, flag_z, flag_c, flag_n, illegal}, 0);
        reset = 0;
        chk_en = 1;

        do_op(3'd0, 8'hF0, 8'h20, 8'h10, 0, 1, 0, 0, 1);
        do_op(3'd1, 8'h05, 8'h05, 8'h00, 1, 0, 0, 0, 1);
        // second SUB raised during DONE: ignored there, accepted one cycle later
        start = 1; op = 3'd1; bus_a = 8'h03; bus_b = 8'h04;
        tick();
        chk("ignored_in_done", busy, 0);
        tick();
        start = 0;
        chk("accepted_after", busy, 1);
        tick();
        chk("sub_borrow", {result_valid, result, flag_z, flag_c, flag_n}, {1'b1, 8'hFF, 1'b0, 1'b1, 1'b1});

        do_op(3'd5, 8'h81, 8'h00, 8'h02, 0, 1, 0, 0, 1);
        do_op(3'd6, 8'h01, 8'h55, 8'h00, 1, 1, 0, 0, 1);
        do_op(3'd2, 8'hCC, 8'hAA, 8'h88, 0, 0, 1, 0, 1);
        do_op(3'd3, 8'hCC, 8'hAA, 8'hEE, 0, 0, 1, 0, 1);
        do_op(3'd4, 8'hCC, 8'hAA, 8'h66, 0, 0, 0, 0, 1);
        if (MUL_EN) begin
            do_op(3'd7, 8'h10, 8'h11, 8'h10, 0, 1, 0, 0, 9);
            do_op(3'd7, 8'h0F, 8'h03, 8'h2D, 0, 0, 0, 0, 9);
        end else begin
            do_op(3'd7, 8'h10, 8'h11, 8'h00, 1, 0, 0, 1, 1);
        end

        // abort in flight: MUL iteration 4 when built in, otherwise mid-EXEC
        tick(); tick();
        start = 1; op = MUL_EN ? 3'd7 : 3'd0; bus_a = 8'h37; bus_b = 8'h5B;
        tick();
        start = 0;
        for (int i = 0; i < (MUL_EN ? 4 : 0); i++) tick();
        reset = 1;
        tick();
        reset = 0;
        chk("abort_zero", {busy, result_valid, result, flag_z, flag_c, flag_n, illegal}, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (result_valid) pulses++; end
        chk("abort_no_pulse", pulses, 0);
        do_op(3'd0, 8'h01, 8'h01, 8'h02, 0, 0, 0, 0, 1);

        // start with new buses while busy must not disturb the in-flight op
        tick(); tick();
        start = 1; op = 3'd0; bus_a = 8'h12; bus_b = 8'h34;
        tick();
        op = 3'd4; bus_a = 8'hFF; bus_b = 8'h0F;
        pulses = 0; seen = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) start = 0;
            if (result_valid) begin pulses++; seen = result; end
        end
        chk("busy_start_pulses", pulses, 1);
        chk("busy_start_result", seen, 8'h46);

        for (int i = 0; i < 600; i++) begin
            tick();
            reset = ($urandom_range(0, 63) == 0);
            start = ($urandom_range(0, 2) == 0);
            op = 3'($urandom);
            bus_a = 8'($urandom);
            bus_b = 8'($urandom);
        end
        reset = 0; start = 0;
        for (int i = 0; i < 12; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
